// File: rtl/fifo_pkt_reader_pkg.sv
// Shared types and constants for the FIFO packet reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_rd_pkg;

    localparam int WIDTH_DEF  = 64;
    localparam int LEN_W_DEF  = 8;
    localparam int SKID_DEPTH = 3;

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } rd_state_t;

    // Circular pointer advance over SKID_DEPTH entries (0,1,2,0,...)
    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// Framed valid/ready packet stream (data plus start/end-of-packet marks).
// Latency: n/a (wires only).
// Backpressure: master holds valid/data/sop/eop until ready is seen high.
interface fifo_pkt_reader_if #(
    parameter int WIDTH = 64
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_sop;
    logic             m_eop;

    modport master (output m_valid, output m_data, output m_sop, output m_eop, input m_ready);
    modport slave  (input m_valid, input m_data, input m_sop, input m_eop, output m_ready);
endinterface

// File: rtl/fifo_pkt_reader_skid_buf3.sv
// 3-entry circular skid buffer holding words returned by the FIFO read port.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: none internally; the caller never pushes into a full buffer without popping.
module skid_buf3
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;

    // Pointer and occupancy next-state; push and pop may coincide, even when full
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
    end

    // Pointer/occupancy registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data storage; contents are meaningless while unoccupied so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains the async FIFO read port into a framed valid/ready stream with packet counting.
// Latency: fifo_rden at cycle t presents the word on m_valid at t+2; 1 beat/cycle sustained.
// Backpressure: at most 3 words buffered; popping stops when buffered + in-flight reaches 3.
module fifo_pkt_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                  rdclk,
    input  logic                  reset,
    output logic                  fifo_rden,
    input  logic [WIDTH-1:0]      fifo_dataout,
    input  logic                  fifo_rdempty,
    fifo_pkt_reader_if.master     strm,
    output logic [15:0]           pkt_cnt
);

    logic             pend_q, pend_d;
    rd_state_t        state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;

    logic [WIDTH-1:0] head;
    logic [1:0]       skid_cnt;
    logic [2:0]       occ;
    logic             m_valid;
    logic             pop;
    logic [LEN_W-1:0] len;
    logic             sop;
    logic             eop;

    // Skid occupancy plus the word still in flight from the FIFO bounds popping;
    // m_ready is deliberately absent so rden has no path from downstream.
    assign occ       = {1'b0, skid_cnt} + {2'b00, pend_q};
    assign fifo_rden = !reset && !fifo_rdempty && (occ <= 3'd2);
    assign pend_d    = fifo_rden;

    skid_buf3 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (rdclk),
        .reset   (reset),
        .push    (pend_q),
        .data_in (fifo_dataout),
        .pop     (pop),
        .head    (head),
        .cnt     (skid_cnt)
    );

    assign m_valid = (skid_cnt != 2'd0);
    assign pop     = m_valid && strm.m_ready;
    assign len     = head[LEN_W-1:0];

    // Framing: header carries the payload count; state only advances on an accepted beat
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        pkt_cnt_d = pkt_cnt_q;
        sop       = 1'b0;
        eop       = 1'b0;
        case (state_q)
            ST_HDR: begin
                sop = 1'b1;
                eop = (len == '0);
                if (pop) begin
                    if (len == '0) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end else begin
                        rem_d   = len;
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                eop = (rem_q == LEN_W'(1));
                if (pop) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        state_d   = ST_HDR;
                    end
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // State registers; reset drops the in-flight word and restarts framing at a header
    always_ff @(posedge rdclk) begin
        if (reset) begin
            pend_q    <= 1'b0;
            state_q   <= ST_HDR;
            rem_q     <= '0;
            pkt_cnt_q <= 16'd0;
        end else begin
            pend_q    <= pend_d;
            state_q   <= state_d;
            rem_q     <= rem_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Framing marks are qualified by valid so they read low while the buffer is empty
    assign strm.m_valid = m_valid;
    assign strm.m_data  = head;
    assign strm.m_sop   = m_valid && sop;
    assign strm.m_eop   = m_valid && eop;
    assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench: behavioural FIFO model, scoreboard of framed beats, directed steps.
// Latency: checks t+2 first-beat timing and 1 beat/cycle streaming.
// Backpressure: checks stall depth, hold-until-accepted and order under toggling ready.
module tb_fifo_pkt_reader;
    import fifo_rd_pkg::*;

    localparam int W     = 64;
    localparam int LW    = 8;
    localparam int MDEPTH = 4096;

    typedef struct packed {
        logic [W-1:0] d;
        logic         sop;
        logic         eop;
    } beat_t;

    logic          rdclk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_rden;
    logic [W-1:0]  fifo_dataout = '0;
    logic          fifo_rdempty;
    logic [15:0]   pkt_cnt;

    fifo_pkt_reader_if #(.WIDTH(W)) strm ();

    fifo_pkt_reader #(
        .WIDTH (W),
        .LEN_W (LW)
    ) dut (
        .rdclk        (rdclk),
        .reset        (reset),
        .fifo_rden    (fifo_rden),
        .fifo_dataout (fifo_dataout),
        .fifo_rdempty (fifo_rdempty),
        .strm         (strm),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 rdclk = ~rdclk;

    int compared   = 0;
    int mismatched = 0;

    // FIFO model: array written by the stimulus, read by the model
    logic [W-1:0] fmem [MDEPTH];
    int           wr_idx = 0;
    int           rd_idx = 0;
    assign fifo_rdempty = (wr_idx == rd_idx);

    beat_t exp_q[$];
    int    exp_pkts = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO read port: one-cycle dataout latency; reset flushes the FIFO too
    always @(posedge rdclk) begin
        if (reset) begin
            rd_idx <= wr_idx;
        end else if (fifo_rden) begin
            chk("no_empty_read", 64'(fifo_rdempty), 64'd0);
            fifo_dataout <= fmem[rd_idx % MDEPTH];
            rd_idx       <= rd_idx + 1;
        end
    end

    // Monitor: scoreboard compare on accepted beats, hold check on stalls, occupancy bound
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data  = '0;
    always @(negedge rdclk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("occ_le3", 64'(({1'b0, dut.skid_cnt} + {2'b00, dut.pend_q}) <= 3'd3), 64'd1);
            if (prev_stall) begin
                chk("hold_valid", 64'(strm.m_valid), 64'd1);
                chk("hold_data", strm.m_data, prev_data);
            end
            if (strm.m_valid && strm.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", strm.m_data, e.d);
                    chk("beat_sop", 64'(strm.m_sop), 64'(e.sop));
                    chk("beat_eop", 64'(strm.m_eop), 64'(e.eop));
                end
            end
            prev_stall = strm.m_valid && !strm.m_ready;
            prev_data  = strm.m_data;
        end
    end

    task automatic push_word(input logic [W-1:0] d, input logic sop, input logic eop);
        beat_t b;
        fmem[wr_idx % MDEPTH] = d;
        wr_idx = wr_idx + 1;
        b.d = d; b.sop = sop; b.eop = eop;
        exp_q.push_back(b);
    endtask

    task automatic push_pkt(input int len);
        logic [W-1:0] h;
        h = {$urandom(), $urandom()};
        h[LW-1:0] = LW'(len);
        push_word(h, 1'b1, len == 0);
        for (int i = 0; i < len; i++) begin
            push_word({$urandom(), $urandom()}, 1'b0, i == len - 1);
        end
        exp_pkts++;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge rdclk);
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge rdclk);
    endtask

    int rden_cnt;

    initial begin
        strm.m_ready = 1'b1;

        // Reset, then idle with an empty FIFO
        repeat (3) @(posedge rdclk);
        @(negedge rdclk);
        chk("rst_valid", 64'(strm.m_valid), 64'd0);
        chk("rst_sop", 64'(strm.m_sop), 64'd0);
        chk("rst_eop", 64'(strm.m_eop), 64'd0);
        @(posedge rdclk); #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rdclk);
            chk("idle_rden", 64'(fifo_rden), 64'd0);
            chk("idle_valid", 64'(strm.m_valid), 64'd0);
            chk("idle_pkt_cnt", 64'(pkt_cnt), 64'd0);
        end

        // Header len=3 + A,B,C: first beat two cycles after the first pop, then back-to-back
        @(posedge rdclk); #1 push_pkt(3);
        @(negedge rdclk);
        chk("lat_rden_t", 64'(fifo_rden), 64'd1);
        chk("lat_valid_t", 64'(strm.m_valid), 64'd0);
        @(negedge rdclk);
        chk("lat_valid_t1", 64'(strm.m_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge rdclk);
            chk("stream_valid", 64'(strm.m_valid), 64'd1);
        end
        wait_drain(50);
        chk("pkt_cnt_1", 64'(pkt_cnt), 64'(exp_pkts));

        // Zero-length packet then len=1 packet
        @(posedge rdclk); #1 push_pkt(0); push_pkt(1);
        wait_drain(50);
        chk("pkt_cnt_3", 64'(pkt_cnt), 64'(exp_pkts));

        // 10-word packet against an 8-cycle stall: only 3 pops before stalling
        @(posedge rdclk); #1 strm.m_ready = 1'b0; push_pkt(9);
        rden_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge rdclk);
            if (fifo_rden) rden_cnt++;
        end
        chk("stall_rden_cnt", 64'(rden_cnt), 64'd3);
        chk("stall_valid", 64'(strm.m_valid), 64'd1);
        chk("stall_skid_full", 64'(dut.skid_cnt), 64'd3);
        @(posedge rdclk); #1 strm.m_ready = 1'b1;
        wait_drain(100);
        chk("pkt_cnt_stall", 64'(pkt_cnt), 64'(exp_pkts));

        // 64 back-to-back random-length packets with ready toggling every cycle
        @(posedge rdclk); #1;
        for (int p = 0; p < 64; p++) push_pkt($urandom_range(0, 15));
        begin
            int n = 0;
            while ((exp_q.size() != 0) && (n < 5000)) begin
                @(posedge rdclk); #1 strm.m_ready = ~strm.m_ready;
                n++;
            end
        end
        strm.m_ready = 1'b1;
        wait_drain(50);
        chk("pkt_cnt_rand", 64'(pkt_cnt), 64'(exp_pkts));

        // Reset in the middle of a body with a word in flight
        @(posedge rdclk); #1 push_pkt(20);
        repeat (6) @(negedge rdclk);
        chk("pre_rst_pend", 64'(dut.pend_q), 64'd1);
        chk("pre_rst_body", 64'(dut.state_q), 64'(ST_BODY));
        @(posedge rdclk); #1 reset = 1'b1; exp_q.delete(); exp_pkts = 0;
        @(negedge rdclk);
        chk("rst_rden_low", 64'(fifo_rden), 64'd0);
        @(posedge rdclk); #1 reset = 1'b0;
        @(negedge rdclk);
        chk("post_rst_valid", 64'(strm.m_valid), 64'd0);
        chk("post_rst_state", 64'(dut.state_q), 64'(ST_HDR));
        chk("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        @(posedge rdclk); #1 push_pkt(2);
        wait_drain(50);
        chk("pkt_cnt_post_rst", 64'(pkt_cnt), 64'(exp_pkts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
